serialize: RTL and testbench
============================

SERIALIZE -- requirements
Module: serialize

Interface
REQ-001 Parameter ITEM_SIZE, default 8: width in bits of one item.
REQ-002 Parameter ITEM_COUNT, default 3: number of items packed in one input word; ITEM_COUNT >= 1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_data  input  ITEM_SIZE*ITEM_COUNT  packed word; item i occupies bits [ITEM_SIZE*(i+1)-1 : ITEM_SIZE*i].
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  the block accepts in_data this cycle.
REQ-008 out_data  output  ITEM_SIZE  current item.
REQ-009 out_valid  output  1  out_data is valid.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_last  output  1  high with out_valid when out_data is item ITEM_COUNT-1 of the word.

Function
REQ-012 Input transfer SHALL occur on a rising edge with in_valid && in_ready; output transfer SHALL occur on a rising edge with out_valid && out_ready.
REQ-013 The block SHALL have two states: EMPTY (no word held) and BUSY (word held in an internal register with an index counter idx of width max(1,clog2(ITEM_COUNT))).
REQ-014 In EMPTY: in_ready=1 and out_valid=0; an input transfer SHALL capture in_data, set idx=0 and go to BUSY.
REQ-015 In BUSY: out_valid=1, out_data=held item idx, out_last=(idx==ITEM_COUNT-1).
REQ-016 In BUSY, an output transfer with idx<ITEM_COUNT-1 SHALL increment idx; the held word SHALL be unchanged.
REQ-017 In BUSY, in_ready SHALL equal out_ready && out_last (combinational); otherwise in_ready=0.
REQ-018 In BUSY, an output transfer of the last item with a simultaneous input transfer SHALL load the new word, set idx=0 and stay BUSY (zero-bubble back-to-back).
REQ-019 In BUSY, an output transfer of the last item without an input transfer SHALL go to EMPTY.
REQ-020 With out_ready=0 in BUSY, out_data, out_last and idx SHALL hold stable until transfer (no dropping, no reordering).
REQ-021 Items SHALL be emitted in ascending index order, item 0 (LSBs) first.
REQ-022 Latency: first item SHALL be valid on the cycle after the input transfer; throughput SHALL be one item per cycle under continuous out_ready.
REQ-023 ITEM_COUNT=1: out_last SHALL be constantly 1 when out_valid, making the block a one-deep pipeline register with full throughput.
REQ-024 in_ready SHALL NOT depend on in_valid; out_valid SHALL NOT depend on out_ready.
REQ-025 in_data SHALL be ignored whenever no input transfer occurs.

Reset
REQ-026 While rst_n=0: state=EMPTY, idx=0, held word=0, out_valid=0, out_last=0, out_data=0, in_ready=0.
REQ-027 After rst_n rises, in_ready SHALL be 1 from the first rising edge onward.
REQ-028 Reset asserted mid-word SHALL discard remaining items immediately; no item of that word SHALL appear after reset.

Verification
REQ-029 ITEM_SIZE=8, ITEM_COUNT=3, out_ready=1, one word 24'hCCBBAA -> out_data AA, BB, CC on consecutive cycles starting one cycle after transfer; out_last only with CC; then out_valid=0.
REQ-030 Two words 24'hCCBBAA, 24'h332211 with in_valid held and out_ready=1 -> AA BB CC 11 22 33 on six consecutive cycles, no bubble; in_ready high only in EMPTY and during the CC cycle.
REQ-031 Word 24'hCCBBAA, out_ready toggling 1,0,0,1,0,1 -> out_data holds BB across stalled cycles; sequence AA BB CC delivered exactly once each.
REQ-032 rst_n pulled low after AA transferred -> out_valid=0 immediately; after release, a new word 24'h030201 yields 01 02 03 only.
REQ-033 ITEM_COUNT=1, continuous stream 8'h10,8'h11,8'h12 with out_ready=1 -> same values one cycle later, out_last=1 each, in_ready stays 1.
REQ-034 Random in_valid/out_ready over 1000 words -> output item stream equals scoreboard of input words unpacked LSB-first; out_last count equals word count.

Source files
------------

// File: rtl/serialize.sv
// serialize -- width-reducing serializer.
//
// Accepts one packed word of ITEM_COUNT items (each ITEM_SIZE bits) and emits
// the items one per cycle, item 0 (LSBs) first, with out_last flagging the
// final item. The last item's output transfer may coincide with the next
// input transfer, so back-to-back words stream with no bubble.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_data    in   packed word, item i at [ITEM_SIZE*(i+1)-1 : ITEM_SIZE*i]
//   in_valid   in   in_data is valid
//   in_ready   out  word is accepted this cycle (independent of in_valid)
//   out_data   out  current item
//   out_valid  out  out_data is valid (independent of out_ready)
//   out_ready  in   downstream accepts out_data this cycle
//   out_last   out  out_data is the last item of the word
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_EMPTY | no word held; in_ready=1 once out of reset, out_valid=0
// ST_BUSY  | word held in word_q, item idx_q presented on out_data

module serialize #(
   parameter int ITEM_SIZE  = 8,
   parameter int ITEM_COUNT = 3
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [ITEM_SIZE*ITEM_COUNT-1:0] in_data,
   input  logic                            in_valid,
   output logic                            in_ready,
   output logic [ITEM_SIZE-1:0]            out_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            out_last
);

   localparam int WORD_W = ITEM_SIZE * ITEM_COUNT;
   localparam int IDX_W  = (ITEM_COUNT > 1) ? $clog2(ITEM_COUNT) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ITEM_COUNT - 1);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_BUSY  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WORD_W-1:0]  word_q, word_d;
   // Low during reset and until the first edge after release, so in_ready
   // stays low while reset is applied and rises on the first clock edge.
   logic               live_q;

   logic               busy;
   logic               last;
   logic               in_xfer;
   logic               out_xfer;
   logic [ITEM_SIZE-1:0] item_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         idx_q   <= '0;
         word_q  <= '0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         live_q  <= 1'b1;
      end
   end

   // Item multiplexer: selects held item idx_q.
   always_comb begin
      item_sel = '0;
      for (int i = 0; i < ITEM_COUNT; i++) begin
         if (idx_q == IDX_W'(i)) begin
            item_sel = word_q[i*ITEM_SIZE +: ITEM_SIZE];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      word_d  = word_q;

      busy      = (state_q == ST_BUSY);
      last      = busy && (idx_q == IDX_LAST);
      out_valid = busy;
      out_last  = last;
      out_data  = busy ? item_sel : '0;
      // In BUSY a new word can only enter as the last item leaves.
      in_ready  = live_q && (!busy || (out_ready && last));

      in_xfer   = in_valid && in_ready;
      out_xfer  = busy && out_ready;

      unique case (state_q)
         ST_EMPTY: begin
            if (in_xfer) begin
               word_d  = in_data;
               idx_d   = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (out_xfer) begin
               if (!last) begin
                  idx_d = idx_q + IDX_W'(1);
               end else if (in_xfer) begin
                  word_d = in_data;
                  idx_d  = '0;
               end else begin
                  idx_d   = '0;
                  state_d = ST_EMPTY;
               end
            end
         end
         default: begin
            state_d = ST_EMPTY;
            idx_d   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_serialize.sv
module tb_serialize;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;

   // DUT A: 8-bit items, 3 per word
   logic [23:0] a_in_data = '0;
   logic        a_in_valid = 1'b0;
   logic        a_in_ready;
   logic [7:0]  a_out_data;
   logic        a_out_valid;
   logic        a_out_ready = 1'b0;
   logic        a_out_last;

   // DUT B: 8-bit items, 1 per word
   logic [7:0]  b_in_data = '0;
   logic        b_in_valid = 1'b0;
   logic        b_in_ready;
   logic [7:0]  b_out_data;
   logic        b_out_valid;
   logic        b_out_ready = 1'b0;
   logic        b_out_last;

   serialize #(.ITEM_SIZE(8), .ITEM_COUNT(3)) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_last(a_out_last)
   );

   serialize #(.ITEM_SIZE(8), .ITEM_COUNT(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_last(b_out_last)
   );

   int total = 0;
   int bad   = 0;

   // scoreboard entries: {last, item}
   logic [8:0] sb_a[$];
   logic [8:0] sb_b[$];
   int a_lasts = 0;
   int a_items = 0;
   int a_words = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a word is the sequence of its items, LSB item first,
   // the final one marked last.
   task automatic push_word_a(input logic [23:0] w);
      for (int i = 0; i < 3; i++) begin
         sb_a.push_back({(i == 2), w[8*i +: 8]});
      end
      a_words++;
   endtask

   // ---------------- monitor ----------------
   logic       a_stall = 1'b0;
   logic [7:0] a_prev_data;
   logic       a_prev_last;

   always @(negedge clk) begin
      logic [8:0] e;
      if (!rst_n) begin
         a_stall = 1'b0;
      end else begin
         check("a_out_valid", {31'd0, a_out_valid}, {31'd0, sb_a.size() != 0});
         check("a_in_ready", {31'd0, a_in_ready},
               {31'd0, !a_out_valid || (a_out_ready && a_out_last)});
         if (a_stall) begin
            check("a_stall_data", {24'd0, a_out_data}, {24'd0, a_prev_data});
            check("a_stall_last", {31'd0, a_out_last}, {31'd0, a_prev_last});
         end
         a_stall     = a_out_valid && !a_out_ready;
         a_prev_data = a_out_data;
         a_prev_last = a_out_last;
         if (a_out_valid && a_out_ready) begin
            if (sb_a.size() == 0) begin
               total++; bad++;
               $display("FAIL a_unexpected_item: got %0h expected none", a_out_data);
            end else begin
               e = sb_a.pop_front();
               check("a_out_data", {24'd0, a_out_data}, {24'd0, e[7:0]});
               check("a_out_last", {31'd0, a_out_last}, {31'd0, e[8]});
               a_items++;
               if (a_out_last) a_lasts++;
            end
         end

         check("b_out_valid", {31'd0, b_out_valid}, {31'd0, sb_b.size() != 0});
         check("b_in_ready", {31'd0, b_in_ready}, {31'd0, !b_out_valid || b_out_ready});
         if (b_out_valid && b_out_ready) begin
            if (sb_b.size() == 0) begin
               total++; bad++;
               $display("FAIL b_unexpected_item: got %0h expected none", b_out_data);
            end else begin
               e = sb_b.pop_front();
               check("b_out_data", {24'd0, b_out_data}, {24'd0, e[7:0]});
               check("b_out_last", {31'd0, b_out_last}, 32'd1);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   // One clock: inputs already driven by caller; note transfers at the
   // negedge, push expectations after the edge that performs them.
   logic a_acc, b_acc;
   task automatic step();
      logic ax, bx;
      logic [23:0] aw;
      logic [7:0]  bw;
      @(negedge clk);
      ax = a_in_valid && a_in_ready;
      bx = b_in_valid && b_in_ready;
      aw = a_in_data;
      bw = b_in_data;
      @(posedge clk);
      if (ax) push_word_a(aw);
      if (bx) sb_b.push_back({1'b1, bw});
      a_acc = ax;
      b_acc = bx;
      #1;
   endtask

   task automatic a_idle(input int n);
      for (int i = 0; i < n; i++) begin
         a_in_valid  = 1'b0;
         a_in_data   = $urandom;
         a_out_ready = 1'b1;
         step();
      end
   endtask

   // Offer a word with out_ready=1 until accepted; returns attempts used.
   task automatic a_send(input logic [23:0] w, output int tries);
      tries = 0;
      a_in_valid  = 1'b1;
      a_in_data   = w;
      a_out_ready = 1'b1;
      do begin
         step();
         tries++;
      end while (!a_acc && tries < 50);
      if (!a_acc) begin
         total++; bad++;
         $display("FAIL a_send_timeout: got no accept expected accept of %0h", w);
      end
      a_in_valid = 1'b0;
      a_in_data  = $urandom;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_a_out_valid"}, {31'd0, a_out_valid}, 32'd0);
      check({tag, "_a_in_ready"},  {31'd0, a_in_ready},  32'd0);
      check({tag, "_a_out_data"},  {24'd0, a_out_data},  32'd0);
      check({tag, "_a_out_last"},  {31'd0, a_out_last},  32'd0);
      check({tag, "_b_in_ready"},  {31'd0, b_in_ready},  32'd0);
      check({tag, "_b_out_valid"}, {31'd0, b_out_valid}, 32'd0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      #2 rst_n = 1'b1;
      #1;
      check("rel_a_in_ready_pre", {31'd0, a_in_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("rel_a_in_ready_post", {31'd0, a_in_ready}, 32'd1);
      check("rel_b_in_ready_post", {31'd0, b_in_ready}, 32'd1);
   endtask

   initial begin
      int tries;
      int l0, w0, cyc;
      logic [23:0] w;

      #1;
      check_reset_outputs("rst");
      repeat (3) @(posedge clk);
      release_reset();

      // single word, continuous out_ready
      l0 = a_lasts;
      a_send(24'hCCBBAA, tries);
      check("single_tries", tries, 1);
      a_idle(5);
      check("single_lasts", a_lasts - l0, 1);

      // two words back to back: second accepted on the CC cycle
      l0 = a_lasts;
      a_send(24'hCCBBAA, tries);
      a_send(24'h332211, tries);
      check("b2b_tries", tries, 3);
      a_idle(5);
      check("b2b_lasts", a_lasts - l0, 2);

      // out_ready stall pattern after acceptance
      l0 = a_lasts;
      a_send(24'hCCBBAA, tries);
      begin
         logic [5:0] pat;
         pat = 6'b101001;   // applied LSB first: 1,0,0,1,0,1
         for (int i = 0; i < 6; i++) begin
            a_out_ready = pat[i];
            step();
         end
      end
      a_idle(3);
      check("stall_lasts", a_lasts - l0, 1);
      check("stall_drained", sb_a.size(), 0);

      // reset mid-word after the first item left
      a_send(24'hCCBBAA, tries);
      a_idle(1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      sb_a.delete();
      sb_b.delete();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("midrst_hold");
      release_reset();
      l0 = a_lasts;
      a_send(24'h030201, tries);
      a_idle(5);
      check("postrst_lasts", a_lasts - l0, 1);

      // ITEM_COUNT=1 stream
      b_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         b_in_valid = 1'b1;
         b_in_data  = 8'h10 + 8'(i);
         step();
         check("b_stream_accept", {31'd0, b_acc}, 32'd1);
      end
      b_in_valid = 1'b0;
      step();
      step();
      check("b_stream_drained", sb_b.size(), 0);

      // randomized traffic on DUT A
      l0 = a_lasts;
      w0 = a_words;
      cyc = 0;
      while ((a_words - w0) < 1000 && cyc < 20000) begin
         w = $urandom;
         a_in_valid  = ($urandom_range(0, 3) != 0);
         a_in_data   = w;
         a_out_ready = ($urandom_range(0, 3) != 0);
         step();
         cyc++;
      end
      check("rand_words", a_words - w0, 1000);
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      cyc = 0;
      while (sb_a.size() != 0 && cyc < 20) begin
         step();
         cyc++;
      end
      check("rand_drained", sb_a.size(), 0);
      check("rand_lasts", a_lasts - l0, a_words - w0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
